// File: rtl/uart_port_switch_pkg.sv
// Shared types and constants for the CPLD UART channel switch controller.
package uart_switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } uart_sw_state_t;

  localparam logic UART_CH1 = 1'b0;
  localparam logic UART_CH2 = 1'b1;

  // Serial lines are held at mark (1) while the CPLD path is being reconfigured.
  function automatic logic line_forced(input uart_sw_state_t s);
    return (s == ST_SWITCH) || (s == ST_SETTLE);
  endfunction

  function automatic logic hold_active(input uart_sw_state_t s);
    return (s == ST_DRAIN) || (s == ST_SWITCH) || (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/uart_port_switch_sync2.sv
// Two-flop bit synchronizer with a configurable reset level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_port_switch.sv
// Drives the CPLD UART select line; drains both directions to idle, switches,
// and holds the lines at mark while the new path settles.
module uart_port_switch
  import uart_switch_pkg::*;
#(
  parameter int IDLE_CYCLES   = 1736,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W = $clog2(IDLE_CYCLES > SETTLE_CYCLES ? IDLE_CYCLES : SETTLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic done,
  output logic busy,
  output logic tx_hold,
  input  logic uart_tx_in,
  output logic uart_tx_out,
  input  logic uart_rx_in,
  output logic uart_rx_out,
  output logic sel_out
);

  localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

  uart_sw_state_t   state_r;
  uart_sw_state_t   state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             sel_pend_r;
  logic             force_r;
  logic             rx_sync_s;
  logic             accept_s;
  logic             lines_idle_s;

  sync2 #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx_in),
    .q   (rx_sync_s)
  );

  assign accept_s     = req_valid & req_ready;
  assign lines_idle_s = uart_tx_out & rx_sync_s;
  assign cnt_inc_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  // Both operands are flops; the force flag pins the synchronized RX at mark.
  assign uart_rx_out  = rx_sync_s | force_r;

  // Next-state and shared counter update.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_sel == sel_out) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_DRAIN;
            cnt_next_s   = '0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!lines_idle_s) begin
          cnt_next_s = '0;
        end else if (cnt_inc_s == IDLE_LAST) begin
          state_next_s = ST_SWITCH;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end
      ST_SWITCH: begin
        state_next_s = ST_SETTLE;
        cnt_next_s   = '0;
      end
      ST_SETTLE: begin
        if (cnt_inc_s == SETTLE_LAST) begin
          state_next_s = ST_DONE;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, counter and all outputs are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      sel_pend_r  <= UART_CH1;
      sel_out     <= UART_CH1;
      uart_tx_out <= 1'b1;
      force_r     <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      tx_hold     <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      sel_pend_r  <= accept_s ? req_sel : sel_pend_r;
      sel_out     <= (state_r == ST_SWITCH) ? sel_pend_r : sel_out;
      uart_tx_out <= line_forced(state_next_s) ? 1'b1 : uart_tx_in;
      force_r     <= line_forced(state_next_s);
      done        <= (state_next_s == ST_DONE);
      busy        <= (state_next_s != ST_IDLE);
      tx_hold     <= hold_active(state_next_s);
      req_ready   <= (state_next_s == ST_IDLE);
    end
  end

endmodule
